// File: rtl/fixed_mac_pkg.sv
// Width and saturation helpers shared by the fixed-point datapath blocks.
package fixed_mac_pkg;

  function automatic int prod_int_w(input int wi1, input int wi2);
    return wi1 + wi2;
  endfunction

  function automatic int prod_frac_w(input int wf1, input int wf2);
    return wf1 + wf2;
  endfunction

  function automatic int sum_int_w(input int prod_int, input int lanes);
    return prod_int + $clog2(lanes);
  endfunction

  function automatic int acc_int_w(input int sum_int, input int guard);
    return sum_int + guard;
  endfunction

  // Largest positive / most negative two's-complement codes of width w (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_sat_resize.sv
// Combinational Qm.n -> Qp.q resize: truncate or round half-up (FIXED_MAC_VEC_ROUND_EN),
// then saturate or wrap the integer part, flagging overflow either way.
module fixed_sat_resize
  import fixed_mac_pkg::*;
#(
  parameter int WI_IN  = 17,
  parameter int WF_IN  = 13,
  parameter int WI_OUT = 16,
  parameter int WF_OUT = 8
) (
  input  logic signed [WI_IN+WF_IN-1:0]   in_data,
  input  logic                            sat_en,
  output logic signed [WI_OUT+WF_OUT-1:0] out_data,
  output logic                            overflow
);

  localparam int WIN  = WI_IN + WF_IN;
  localparam int WOUT = WI_OUT + WF_OUT;
  // One spare integer bit absorbs the rounding carry.
  localparam int WM   = WI_IN + 1 + WF_OUT;

  logic signed [WM-1:0] mid;

  generate
    if (WF_OUT >= WF_IN) begin : g_pad
      assign mid = WM'(in_data) <<< (WF_OUT - WF_IN);
    end else begin : g_drop
      localparam int D  = WF_IN - WF_OUT;
      localparam int WE = WIN + 1;
      logic signed [WE-1:0] ext;
      always_comb begin
        ext = WE'(in_data);
`ifdef FIXED_MAC_VEC_ROUND_EN
        ext = ext + (WE'(1) <<< (D - 1));
`endif
      end
      assign mid = WM'(ext >>> D);
    end

    if (WI_OUT >= WI_IN + 1) begin : g_fit
      logic unused_sat;
      assign unused_sat = sat_en;
      assign overflow   = 1'b0;
      assign out_data   = WOUT'(mid);
    end else begin : g_narrow
      logic [WM-WOUT:0] top;
      assign top = mid[WM-1:WOUT-1];
      always_comb begin
        overflow = !((&top) || !(|top));
        if (overflow && sat_en) begin
          out_data = mid[WM-1] ? WOUT'(sat_min(WOUT)) : WOUT'(sat_max(WOUT));
        end else begin
          out_data = mid[WOUT-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fixed_mac_vec.sv
// Vector fixed-point MAC: LANES signed products per beat, accumulated per packet, resized to Q(WIO).(WFO).
// Optional FIXED_MAC_VEC_ROUND_EN selects round half-up instead of truncation in the resize.
module fixed_mac_vec
  import fixed_mac_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WI1       = 4,
  parameter int WF1       = 8,
  parameter int WI2       = 3,
  parameter int WF2       = 5,
  parameter int WIO       = 16,
  parameter int WFO       = 8,
  parameter int ACC_GUARD = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES*(WI1+WF1)-1:0]    in_a,
  input  logic [LANES*(WI2+WF2)-1:0]    in_b,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  output logic signed [WIO+WFO-1:0]     out_data,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_overflow,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  input  logic                          sat_en
);

  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int PI = prod_int_w(WI1, WI2);
  localparam int PF = prod_frac_w(WF1, WF2);
  localparam int PW = PI + PF;
  localparam int SI = sum_int_w(PI, LANES);
  localparam int SW = SI + PF;
  localparam int AI = acc_int_w(SI, ACC_GUARD);
  localparam int AW = AI + PF;
  localparam int WO = WIO + WFO;

  logic                   en;
  logic                   accept;
  logic [LANES*WA-1:0]    a_p0;
  logic [LANES*WB-1:0]    b_p0;
  logic                   vld_p0, last_p0;
  logic signed [PW-1:0]   prod_p1 [LANES];
  logic                   vld_p1, last_p1;
  logic signed [AW-1:0]   acc_p2;
  logic [CNT_W-1:0]       cnt_p2;
  logic signed [SW-1:0]   lane_sum;
  logic signed [AW-1:0]   acc_next;
  logic [CNT_W-1:0]       cnt_next;
  logic signed [WO-1:0]   res;
  logic                   res_ovf;

  // A held result freezes the whole pipe so no beat is lost.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !reset;
  assign accept   = in_valid && in_ready;
  assign out_last = out_valid;

  // ---- p0: operand capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (en) begin
      vld_p0  <= accept;
      last_p0 <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a_p0 <= in_a;
      b_p0 <= in_b;
    end
  end

  // ---- p1: full-precision lane products ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i] <= PW'($signed(a_p0[i*WA +: WA])) * PW'($signed(b_p0[i*WB +: WB]));
      end
    end
  end

  // ---- p2: lane sum, accumulate, resize into the output register ----
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SW'(prod_p1[i]);
    end
  end

  assign acc_next = acc_p2 + AW'(lane_sum);
  assign cnt_next = (&cnt_p2) ? cnt_p2 : cnt_p2 + CNT_W'(1);

  fixed_sat_resize #(
    .WI_IN  (AI),
    .WF_IN  (PF),
    .WI_OUT (WIO),
    .WF_OUT (WFO)
  ) u_resize (
    .in_data  (acc_next),
    .sat_en   (sat_en),
    .out_data (res),
    .overflow (res_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2       <= '0;
      cnt_p2       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (en) begin
      if (vld_p1 && !last_p1) begin
        acc_p2 <= acc_next;
        cnt_p2 <= cnt_next;
      end
      if (vld_p1 && last_p1) begin
        acc_p2       <= '0;
        cnt_p2       <= '0;
        out_valid    <= 1'b1;
        out_data     <= res;
        out_count    <= cnt_next;
        out_overflow <= res_ovf;
      end else if (out_valid) begin
        out_valid    <= 1'b0;
        out_data     <= '0;
        out_count    <= '0;
        out_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mac_vec.sv
// Directed bench for fixed_mac_vec: default Q16.8 instance plus a WIO=4 instance for overflow cases.
module tb_fixed_mac_vec;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] in_a;
  logic [31:0] in_b;
  logic        in_valid, in_last, out_ready, sat_en;
  logic        in_ready, out_valid, out_last, out_overflow;
  logic [23:0] out_data;
  logic [15:0] out_count;
  logic        in_ready4, out_valid4, out_last4, out_overflow4;
  logic [11:0] out_data4;
  logic [15:0] out_count4;

  int total = 0;
  int bad   = 0;

  logic        fire, acc_fire, c_ovf, c_ovf4;
  logic [23:0] c_data;
  logic [11:0] c_data4;
  logic [15:0] c_cnt;

  fixed_mac_vec dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sat_en(sat_en)
  );

  fixed_mac_vec #(.WIO(4)) dut4 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready4), .in_last(in_last), .out_data(out_data4), .out_count(out_count4),
    .out_overflow(out_overflow4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_last(out_last4), .sat_en(sat_en)
  );

  always #5 clk = ~clk;

  // Record handshakes and the values present at the handshaking edge.
  always @(posedge clk) begin
    fire     <= out_valid && out_ready;
    acc_fire <= in_valid && in_ready;
    c_data   <= out_data;
    c_cnt    <= out_count;
    c_ovf    <= out_overflow;
    c_data4  <= out_data4;
    c_ovf4   <= out_overflow4;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [47:0] a, input logic [31:0] b, input logic last);
    int t;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!acc_fire && t < 200);
    chk("beat_accepted", acc_fire, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!fire && t < 100);
    chk({tag, "_seen"}, fire, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; sat_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_overflow", out_overflow, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Test 1: single beat of 1.0*1.0 on all lanes, two-edge latency after accept
    send({4{12'h100}}, {4{8'h20}}, 1'b1);
    chk("t1_lat0", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", out_valid, 1);
    chk("t1_data", out_data, 24'h000400);
    chk("t1_count", out_count, 1);
    chk("t1_ovf", out_overflow, 0);
    chk("t1_last", out_last, 1);

    // Test 2: stray in_last without valid, then three beats of 0.5*-1.0
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    send({4{12'h080}}, {4{8'hE0}}, 1'b0);
    send({4{12'h080}}, {4{8'hE0}}, 1'b0);
    send({4{12'h080}}, {4{8'hE0}}, 1'b1);
    wait_out("t2");
    chk("t2_data", c_data, 24'hFFFA00);
    chk("t2_count", c_cnt, 3);
    chk("t2_ovf", c_ovf, 0);

    // Test 3: 8.0 overflows Q4.8 on the narrow instance
    sat_en = 1'b1;
    send({4{12'h100}}, {4{8'h20}}, 1'b0);
    send({4{12'h100}}, {4{8'h20}}, 1'b1);
    wait_out("t3s");
    chk("t3s_data4", c_data4, 12'h7FF);
    chk("t3s_ovf4", c_ovf4, 1);
    chk("t3s_data", c_data, 24'h000800);
    chk("t3s_ovf", c_ovf, 0);
    sat_en = 1'b0;
    send({4{12'h100}}, {4{8'h20}}, 1'b0);
    send({4{12'h100}}, {4{8'h20}}, 1'b1);
    wait_out("t3w");
    chk("t3w_data4", c_data4, 12'h800);
    chk("t3w_ovf4", c_ovf4, 1);
    sat_en = 1'b1;

    // Test 4: consumer stalls while packets stream back-to-back
    out_ready = 1'b0;
    fork
      begin
        send({4{12'h100}}, {4{8'h20}}, 1'b1);
        send({4{12'h100}}, {4{8'h40}}, 1'b0);
        send({4{12'h100}}, {4{8'h40}}, 1'b1);
        send({4{12'h080}}, {4{8'hE0}}, 1'b1);
        send({4{12'hF00}}, {4{8'h60}}, 1'b1);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t4_stall_in_ready", in_ready, 0);
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_data", out_data, 24'h000400);
        out_ready = 1'b1;
        wait_out("t4_r0");
        chk("t4_r0_data", c_data, 24'h000400);
        chk("t4_r0_count", c_cnt, 1);
        wait_out("t4_r1");
        chk("t4_r1_data", c_data, 24'h001000);
        chk("t4_r1_count", c_cnt, 2);
        wait_out("t4_r2");
        chk("t4_r2_data", c_data, 24'hFFFE00);
        chk("t4_r2_count", c_cnt, 1);
        wait_out("t4_r3");
        chk("t4_r3_data", c_data, 24'hFFF400);
        chk("t4_r3_count", c_cnt, 1);
      end
    join

    // Test 5: reset mid-packet discards the partial accumulation
    send({4{12'h100}}, {4{8'h20}}, 1'b0);
    send({4{12'h100}}, {4{8'h20}}, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_valid_after_rst", out_valid, 0);
    send({4{12'h100}}, {4{8'h20}}, 1'b1);
    wait_out("t5");
    chk("t5_data", c_data, 24'h000400);
    chk("t5_count", c_cnt, 1);

    // Test 6: sub-LSB product 2^-9 on lane 0 only
    send({36'h0, 12'h001}, {24'h0, 8'h10}, 1'b1);
    wait_out("t6");
`ifdef FIXED_MAC_VEC_ROUND_EN
    chk("t6_data", c_data, 24'h000001);
`else
    chk("t6_data", c_data, 24'h000000);
`endif
    chk("t6_ovf", c_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
